// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer.
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_R      = 4'd1,
    CL_I      = 4'd2,
    CL_LOAD   = 4'd3,
    CL_STORE  = 4'd4,
    CL_BRANCH = 4'd5,
    CL_JAL    = 4'd6,
    CL_JALR   = 4'd7,
    CL_LUI    = 4'd8,
    CL_AUIPC  = 4'd9
  } class_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [1:0] ALUOP_JUMP  = 2'b11;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic       aSel;
    logic       bSel;
  } alu_ctrl_t;

  // ALUOp and operand selects an instruction class uses in EXEC (and keeps through MEM/WB).
  function automatic alu_ctrl_t aluCtrlFor(class_t cls);
    alu_ctrl_t c;
    c.op   = ALUOP_MEM;
    c.aSel = 1'b0;
    c.bSel = 1'b0;
    case (cls)
      CL_R:               c.op = ALUOP_ARITH;
      CL_I:     begin     c.op = ALUOP_ARITH; c.bSel = 1'b1; end
      CL_LOAD,
      CL_STORE: begin     c.op = ALUOP_MEM;   c.bSel = 1'b1; end
      CL_BRANCH:          c.op = ALUOP_BR;
      CL_JAL:   begin     c.op = ALUOP_JUMP;  c.aSel = 1'b1; c.bSel = 1'b1; end
      CL_JALR:  begin     c.op = ALUOP_JUMP;  c.bSel = 1'b1; end
      CL_AUIPC: begin     c.op = ALUOP_MEM;   c.aSel = 1'b1; c.bSel = 1'b1; end
      CL_LUI:   begin     c.op = ALUOP_MEM;   c.bSel = 1'b1; end
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_classifier.sv
// Combinational opcode -> instruction class decoder with an illegal-opcode flag.
module opcode_classifier
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode_i,
  output class_t     class_o,
  output logic       illegal_o
);

  // Map the 7-bit major opcode onto a class; anything unrecognised is flagged illegal.
  always_comb begin
    class_o   = CL_NONE;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_R:      class_o = CL_R;
      OPC_I:      class_o = CL_I;
      OPC_LOAD:   class_o = CL_LOAD;
      OPC_STORE:  class_o = CL_STORE;
      OPC_BRANCH: class_o = CL_BRANCH;
      OPC_JAL:    class_o = CL_JAL;
      OPC_JALR:   class_o = CL_JALR;
      OPC_LUI:    class_o = CL_LUI;
      OPC_AUIPC:  class_o = CL_AUIPC;
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout trap
// and a retired-instruction counter. MEM_TIMEOUT must be at least 1.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        alu_branch_true,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_write,
  output logic [1:0]  alu_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        trap,
  output logic [31:0] instret
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t        state_q;
  class_t        class_q;
  logic [CW-1:0] waitCnt_q;
  logic [31:0]   instret_q;

  class_t        decClass;
  logic          decIllegal;
  logic          waitLast;
  alu_ctrl_t     aluCtrl;

  opcode_classifier u_classifier (
    .opcode_i  (opcode),
    .class_o   (decClass),
    .illegal_o (decIllegal)
  );

  assign waitLast = (waitCnt_q == CW'(MEM_TIMEOUT - 1));
  assign aluCtrl  = aluCtrlFor(class_q);
  assign instret  = instret_q;

  // Sequencer state, latched class, memory wait counter and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      class_q   <= CL_NONE;
      waitCnt_q <= '0;
      instret_q <= '0;
    end else begin
      if (pc_write) begin
        instret_q <= instret_q + 32'd1;
      end
      case (state_q)
        ST_BOOT: begin
          state_q   <= ST_FETCH;
          waitCnt_q <= '0;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            state_q <= ST_DECODE;
          end else if (waitLast) begin
            state_q <= ST_TRAP;
          end else begin
            waitCnt_q <= waitCnt_q + CW'(1);
          end
        end
        ST_DECODE: begin
          if (decIllegal) begin
            state_q <= ST_TRAP;
          end else begin
            class_q <= decClass;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (class_q == CL_BRANCH) begin
            state_q   <= ST_FETCH;
            waitCnt_q <= '0;
          end else if (class_q == CL_LOAD || class_q == CL_STORE) begin
            state_q   <= ST_MEM;
            waitCnt_q <= '0;
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ready) begin
            if (class_q == CL_STORE) begin
              state_q   <= ST_FETCH;
              waitCnt_q <= '0;
            end else begin
              state_q <= ST_WB;
            end
          end else if (waitLast) begin
            state_q <= ST_TRAP;
          end else begin
            waitCnt_q <= waitCnt_q + CW'(1);
          end
        end
        ST_WB: begin
          state_q   <= ST_FETCH;
          waitCnt_q <= '0;
        end
        ST_TRAP: state_q <= ST_TRAP;
        default: state_q <= ST_TRAP;
      endcase
    end
  end

  // Output decode from state and latched class; ready and branch inputs only gate strobes.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    alu_op    = ALUOP_MEM;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_SEL_ALU;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_PLUS4;
    trap      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      ST_EXEC: begin
        alu_op    = aluCtrl.op;
        alu_a_sel = aluCtrl.aSel;
        alu_b_sel = aluCtrl.bSel;
        if (class_q == CL_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = alu_branch_true ? PC_SRC_BRANCH : PC_SRC_PLUS4;
        end
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = (class_q == CL_STORE);
        alu_op    = ALUOP_MEM;
        alu_b_sel = 1'b1;
        if (dmem_ready && class_q == CL_STORE) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_PLUS4;
        end
      end
      ST_WB: begin
        alu_op    = aluCtrl.op;
        alu_a_sel = aluCtrl.aSel;
        alu_b_sel = aluCtrl.bSel;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (class_q)
          CL_LOAD:         wb_sel = WB_SEL_MEM;
          CL_JAL, CL_JALR: wb_sel = WB_SEL_PC4;
          CL_LUI:          wb_sel = WB_SEL_IMM;
          default:         wb_sel = WB_SEL_ALU;
        endcase
        case (class_q)
          CL_JAL:  pc_src = PC_SRC_BRANCH;
          CL_JALR: pc_src = PC_SRC_JALR;
          default: pc_src = PC_SRC_PLUS4;
        endcase
      end
      ST_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: builds a per-cycle expectation plan
// from instruction-level rules, replays it against the DUT and compares every cycle.
module tb_multicycle_control;

  localparam int MEM_TIMEOUT = 15;
  localparam int K_ILLEGAL = 0;
  localparam int K_WB      = 1;
  localparam int K_LOAD    = 2;
  localparam int K_STORE   = 3;
  localparam int K_BRANCH  = 4;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        alu_branch_true;
  logic        imem_req;
  logic        imem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        ir_write;
  logic [1:0]  alu_op;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        trap;
  logic [31:0] instret;

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode          (opcode),
    .alu_branch_true (alu_branch_true),
    .imem_req        (imem_req),
    .imem_ready      (imem_ready),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_ready      (dmem_ready),
    .ir_write        (ir_write),
    .alu_op          (alu_op),
    .alu_a_sel       (alu_a_sel),
    .alu_b_sel       (alu_b_sel),
    .reg_write       (reg_write),
    .wb_sel          (wb_sel),
    .pc_write        (pc_write),
    .pc_src          (pc_src),
    .trap            (trap),
    .instret         (instret)
  );

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] dutVec;
  assign dutVec = {imem_req, dmem_req, dmem_we, ir_write, alu_op, alu_a_sel, alu_b_sel,
                   reg_write, wb_sel, pc_write, pc_src, trap};

  typedef struct packed {
    logic        rstN;
    logic        imRdy;
    logic        dmRdy;
    logic        brT;
    logic [6:0]  opc;
    logic [14:0] expVec;
    logic [31:0] expInstret;
    int          pinInstret;
    int          pinTrap;
    int          pinRun;
  } cycle_t;

  cycle_t plan[$];
  string  tags[$];
  int     mInstret    = 0;
  int     pendInstret = -1;
  int     pendTrap    = -1;
  int     pendRun     = -1;
  int     runCnt      = 0;
  int     lastRun     = 0;
  int     nChecks     = 0;
  int     nPass       = 0;

  function automatic logic [14:0] mk(input logic imReq, input logic dmReq, input logic dmWe,
                                     input logic irW, input logic [1:0] aop, input logic aS,
                                     input logic bS, input logic rW, input logic [1:0] wbs,
                                     input logic pcW, input logic [1:0] pcs, input logic trp);
    return {imReq, dmReq, dmWe, irW, aop, aS, bS, rW, wbs, pcW, pcs, trp};
  endfunction

  function automatic int shapeOf(input logic [6:0] opc, output logic [1:0] aop, output logic aS,
                                 output logic bS, output logic [1:0] wbs, output logic [1:0] pcs);
    int k;
    aop = 2'b00; aS = 1'b0; bS = 1'b0; wbs = 2'b00; pcs = 2'b00;
    k = K_WB;
    case (opc)
      7'h33: aop = 2'b10;
      7'h13: begin aop = 2'b10; bS = 1'b1; end
      7'h03: begin bS = 1'b1; wbs = 2'b01; k = K_LOAD; end
      7'h23: begin bS = 1'b1; k = K_STORE; end
      7'h63: begin aop = 2'b01; k = K_BRANCH; end
      7'h6F: begin aop = 2'b11; aS = 1'b1; bS = 1'b1; wbs = 2'b10; pcs = 2'b01; end
      7'h67: begin aop = 2'b11; bS = 1'b1; wbs = 2'b10; pcs = 2'b10; end
      7'h37: begin bS = 1'b1; wbs = 2'b11; end
      7'h17: begin aS = 1'b1; bS = 1'b1; end
      default: k = K_ILLEGAL;
    endcase
    return k;
  endfunction

  task automatic pushCycle(input string tag, input logic rstN, input logic imRdy, input logic dmRdy,
                           input logic brT, input logic [6:0] opc, input logic [14:0] ev);
    cycle_t c;
    c.rstN       = rstN;
    c.imRdy      = imRdy;
    c.dmRdy      = dmRdy;
    c.brT        = brT;
    c.opc        = opc;
    c.expVec     = ev;
    c.expInstret = 32'(mInstret);
    c.pinInstret = pendInstret;
    c.pinTrap    = pendTrap;
    c.pinRun     = pendRun;
    pendInstret  = -1;
    pendTrap     = -1;
    pendRun      = -1;
    plan.push_back(c);
    tags.push_back(tag);
  endtask

  task automatic pushTrap(input string nm, input int n);
    for (int i = 0; i < n; i++)
      pushCycle({nm, " trap"}, 1'b1, 1'b1, 1'b1, 1'b1, 7'h00,
                mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 1));
  endtask

  task automatic pushReset();
    mInstret = 0;
    pushCycle("reset", 1'b0, 1'b1, 1'b1, 1'b1, 7'h00, 15'd0);
    pushCycle("boot", 1'b1, 1'b1, 1'b1, 1'b1, 7'h00, 15'd0);
  endtask

  task automatic planInstr(input string nm, input logic [6:0] opc, input int fWaits,
                           input int mWaits, input logic brT, input bit abortMem);
    logic [1:0] aop, wbs, pcs;
    logic aS, bS, st;
    int k;
    k = shapeOf(opc, aop, aS, bS, wbs, pcs);
    for (int i = 0; i < fWaits && i < MEM_TIMEOUT; i++)
      pushCycle({nm, " fetch-wait"}, 1'b1, 1'b0, 1'b1, 1'b1, opc,
                mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 0));
    if (fWaits >= MEM_TIMEOUT) begin
      pushTrap(nm, 4);
      return;
    end
    pushCycle({nm, " fetch"}, 1'b1, 1'b1, 1'b0, 1'b1, opc,
              mk(1, 0, 0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 0));
    pushCycle({nm, " decode"}, 1'b1, 1'b1, 1'b1, 1'b1, opc, 15'd0);
    if (k == K_ILLEGAL) begin
      pushTrap(nm, 4);
      return;
    end
    if (k == K_BRANCH) begin
      pushCycle({nm, " exec-branch"}, 1'b1, 1'b1, 1'b1, brT, opc,
                mk(0, 0, 0, 0, aop, aS, bS, 0, 2'b00, 1, brT ? 2'b01 : 2'b00, 0));
      mInstret++;
      return;
    end
    pushCycle({nm, " exec"}, 1'b1, 1'b1, 1'b1, 1'b1, opc,
              mk(0, 0, 0, 0, aop, aS, bS, 0, 2'b00, 0, 2'b00, 0));
    if (k == K_LOAD || k == K_STORE) begin
      st = (k == K_STORE);
      for (int i = 0; i < mWaits && i < MEM_TIMEOUT; i++)
        pushCycle({nm, " mem-wait"}, 1'b1, 1'b1, 1'b0, 1'b1, opc,
                  mk(0, 1, st, 0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 0));
      if (abortMem) return;
      if (mWaits >= MEM_TIMEOUT) begin
        pushTrap(nm, 4);
        return;
      end
      if (st) begin
        pushCycle({nm, " mem-store"}, 1'b1, 1'b0, 1'b1, 1'b1, opc,
                  mk(0, 1, 1, 0, 2'b00, 0, 1, 0, 2'b00, 1, 2'b00, 0));
        mInstret++;
        return;
      end
      pushCycle({nm, " mem-load"}, 1'b1, 1'b0, 1'b1, 1'b1, opc,
                mk(0, 1, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 0));
    end
    pushCycle({nm, " wb"}, 1'b1, 1'b1, 1'b1, 1'b1, opc,
              mk(0, 0, 0, 0, aop, aS, bS, 1, wbs, 1, pcs, 0));
    mInstret++;
  endtask

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkOutput(input cycle_t c, input string tag);
    checkEq({tag, " outputs"}, {17'd0, dutVec}, {17'd0, c.expVec});
    checkEq({tag, " instret"}, instret, c.expInstret);
    if (c.pinInstret >= 0) checkEq({tag, " pinned instret"}, instret, 32'(c.pinInstret));
    if (c.pinTrap >= 0)    checkEq({tag, " pinned trap"}, {31'd0, trap}, 32'(c.pinTrap));
    if (c.pinRun >= 0)     checkEq({tag, " pinned fetch run"}, 32'(lastRun), 32'(c.pinRun));
  endtask

  task automatic applyStimulus();
    cycle_t c;
    string  tag;
    while (plan.size() > 0) begin
      c   = plan.pop_front();
      tag = tags.pop_front();
      @(posedge clk);
      #1;
      reset           = c.rstN;
      imem_ready      = c.imRdy;
      dmem_ready      = c.dmRdy;
      alu_branch_true = c.brT;
      opcode          = c.opc;
      @(negedge clk);
      checkOutput(c, tag);
      if (imem_req === 1'b1) runCnt++;
      else begin
        if (runCnt > 0) lastRun = runCnt;
        runCnt = 0;
      end
    end
  endtask

  // Build the directed instruction plan, replay it and report.
  initial begin
    reset           = 1'b0;
    imem_ready      = 1'b0;
    dmem_ready      = 1'b0;
    alu_branch_true = 1'b0;
    opcode          = 7'h00;
    repeat (3) @(posedge clk);

    pushReset();
    planInstr("add", 7'h33, 0, 0, 1'b1, 1'b0);
    pendInstret = 1;
    planInstr("lw", 7'h03, 1, 3, 1'b1, 1'b0);
    planInstr("sw", 7'h23, 0, 3, 1'b1, 1'b0);
    pendInstret = 3;
    planInstr("beq", 7'h63, 0, 0, 1'b1, 1'b0);
    planInstr("bne", 7'h63, 2, 0, 1'b0, 1'b0);
    pendInstret = 5;
    planInstr("jal", 7'h6F, 0, 0, 1'b1, 1'b0);
    planInstr("jalr", 7'h67, 0, 0, 1'b1, 1'b0);
    pendInstret = 7;
    planInstr("addi", 7'h13, 0, 0, 1'b1, 1'b0);
    planInstr("lui", 7'h37, 0, 0, 1'b1, 1'b0);
    planInstr("auipc", 7'h17, 0, 0, 1'b1, 1'b0);
    pendInstret = 10;
    planInstr("add-late", 7'h33, 14, 0, 1'b1, 1'b0);
    pendInstret = 11;
    pendRun     = 15;
    planInstr("fetch-timeout", 7'h33, 15, 0, 1'b1, 1'b0);
    pendTrap    = 1;
    pendInstret = 11;
    pushTrap("hold", 2);
    pendRun = 15;
    pushReset();
    planInstr("lw-timeout", 7'h03, 0, 20, 1'b1, 1'b0);
    pendTrap    = 1;
    pendInstret = 0;
    pushTrap("hold", 2);
    pushReset();
    planInstr("add", 7'h33, 0, 0, 1'b1, 1'b0);
    planInstr("illegal", 7'h7F, 0, 0, 1'b1, 1'b0);
    pendTrap    = 1;
    pendInstret = 1;
    pushTrap("hold", 2);
    pushReset();
    planInstr("add", 7'h33, 0, 0, 1'b1, 1'b0);
    planInstr("lw-abort", 7'h03, 0, 2, 1'b1, 1'b1);
    pendInstret = 0;
    pendTrap    = 0;
    pushReset();
    planInstr("add", 7'h33, 0, 0, 1'b1, 1'b0);
    pendInstret = 1;
    planInstr("sw", 7'h23, 0, 0, 1'b1, 1'b0);

    applyStimulus();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
